neural_mac_sequencer: RTL

//  Time-multiplexed sequencer for the 2-input, 2-hidden, 2-output neural network.

---
 rtl/neural_pkg.sv | 36 +++
 rtl/neural_mac_unit.sv | 42 ++++
 rtl/neural_mac_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/neural_pkg.sv
// Shared constants, FSM state type and config address map for the
// neural MAC sequencer.
package neural_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1N1 = 3'd1,
    L1N2 = 3'd2,
    L2N1 = 3'd3,
    L2N2 = 3'd4,
    DONE = 3'd5
  } state_e;

  // Weight slots 0..7 (cLNI, row-major), bias slots 8..11.
  localparam logic [3:0] ADDR_C111 = 4'd0;
  localparam logic [3:0] ADDR_C112 = 4'd1;
  localparam logic [3:0] ADDR_C121 = 4'd2;
  localparam logic [3:0] ADDR_C122 = 4'd3;
  localparam logic [3:0] ADDR_C211 = 4'd4;
  localparam logic [3:0] ADDR_C212 = 4'd5;
  localparam logic [3:0] ADDR_C221 = 4'd6;
  localparam logic [3:0] ADDR_C222 = 4'd7;
  localparam logic [3:0] ADDR_B11  = 4'd8;
  localparam logic [3:0] ADDR_B12  = 4'd9;
  localparam logic [3:0] ADDR_B21  = 4'd10;
  localparam logic [3:0] ADDR_B22  = 4'd11;
  localparam logic [3:0] ADDR_LIMIT = 4'd12;
  localparam int         NUM_PARAMS = 12;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/neural_mac_unit.sv
// Combinational signed fixed-point MAC: sum_out = sat(acc_in + sat(a*b >>> FRAC)).
module neural_mac_unit #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] sum_out
);

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [2*W-1:0] a_ext, b_ext, prod;
  logic [W-1:0]          mul_sat;
  logic signed [W:0]     sum_ext;

  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};
  assign prod  = a_ext * b_ext;

  // The realigned product fits W bits only if every bit above it matches the sign.
  always_comb begin
    mul_sat = prod[W+FRAC-1:FRAC];
    if (!prod[2*W-1] && (|prod[2*W-2:W+FRAC-1])) begin
      mul_sat = MAXV;
    end else if (prod[2*W-1] && !(&prod[2*W-2:W+FRAC-1])) begin
      mul_sat = MINV;
    end
  end

  assign sum_ext = {acc_in[W-1], acc_in} + {mul_sat[W-1], mul_sat};

  always_comb begin
    sum_out = sum_ext[W-1:0];
    if (sum_ext[W] != sum_ext[W-1]) begin
      sum_out = sum_ext[W] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/neural_mac_sequencer.sv
// 2-2-2 neural network evaluated on one shared MAC, two cycles per neuron.
// Build option: NEURAL_SEQ_RELU_EN selects ReLU activation (default linear).
module neural_mac_sequencer
  import neural_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int FRAC = FRAC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] inputA,
  input  logic [W-1:0] inputB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2
);

  state_e       state_q, state_d;
  logic         step_q, step_d;
  logic [W-1:0] param_q [NUM_PARAMS];
  logic [W-1:0] xa_q, xb_q, h1_q, h2_q, acc_q, out1_q, out2_q;

  logic         busy;
  logic [W-1:0] w1, w2, x1, x2, bias;
  logic [W-1:0] mac_a, mac_b, mac_acc, mac_sum, act_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = L1N1;
        step_d  = 1'b0;
      end
      L1N1, L1N2, L2N1, L2N2: begin
        step_d = ~step_q;
        if (step_q) begin
          unique case (state_q)
            L1N1:    state_d = L1N2;
            L1N2:    state_d = L2N1;
            L2N1:    state_d = L2N2;
            default: state_d = DONE;
          endcase
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign busy = (state_q == L1N1) || (state_q == L1N2) ||
                (state_q == L2N1) || (state_q == L2N2);

  always_comb begin
    w1   = param_q[ADDR_C111];
    w2   = param_q[ADDR_C112];
    bias = param_q[ADDR_B11];
    x1   = xa_q;
    x2   = xb_q;
    unique case (state_q)
      L1N2: begin
        w1   = param_q[ADDR_C121];
        w2   = param_q[ADDR_C122];
        bias = param_q[ADDR_B12];
      end
      L2N1: begin
        w1   = param_q[ADDR_C211];
        w2   = param_q[ADDR_C212];
        bias = param_q[ADDR_B21];
        x1   = h1_q;
        x2   = h2_q;
      end
      L2N2: begin
        w1   = param_q[ADDR_C221];
        w2   = param_q[ADDR_C222];
        bias = param_q[ADDR_B22];
        x1   = h1_q;
        x2   = h2_q;
      end
      default: ;
    endcase
  end

  // Step 0 seeds the accumulator with the bias; step 1 folds in the second term.
  assign mac_a   = step_q ? w2    : w1;
  assign mac_b   = step_q ? x2    : x1;
  assign mac_acc = step_q ? acc_q : bias;

  neural_mac_unit #(.W(W), .FRAC(FRAC)) u_mac (
    .a       (mac_a),
    .b       (mac_b),
    .acc_in  (mac_acc),
    .sum_out (mac_sum)
  );

`ifdef NEURAL_SEQ_RELU_EN
  assign act_sum = mac_sum[W-1] ? '0 : mac_sum;
`else
  assign act_sum = mac_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
      xa_q   <= '0;
      xb_q   <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      acc_q  <= '0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      if (cfg_we && (state_q == IDLE) && (cfg_addr < ADDR_LIMIT)) begin
        param_q[cfg_addr] <= cfg_wdata;
      end
      if (in_valid && in_ready) begin
        xa_q <= inputA;
        xb_q <= inputB;
      end
      if (busy) begin
        if (!step_q) begin
          acc_q <= mac_sum;
        end else begin
          unique case (state_q)
            L1N1:    h1_q   <= act_sum;
            L1N2:    h2_q   <= act_sum;
            L2N1:    out1_q <= act_sum;
            default: out2_q <= act_sum;
          endcase
        end
      end
    end
  end

  assign out1 = out1_q;
  assign out2 = out2_q;

endmodule
